sr_ff_monitor: RTL

- Passive checker at the observing end of the SR flip-flop interface. A stimulus source drives s/r into an sr_ff instance; this block watches the same s/r/q/q_bar.
- Runs a cycle-accurate golden model of the flop and flags output mismatches, complement violations and illegal S=R=1 requests.
- Keeps saturating statistics counters. Synthesizable, so it can ship on-chip next to the flop as a self-check, or sit in a bench as a scoreboard.

---
 rtl/sr_mon_pkg.sv | 17 +
 rtl/sat_counter.sv | 29 ++
 rtl/sr_ff_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sr_mon_pkg.sv
// Shared types and constants for the SR flip-flop monitor.
package sr_mon_pkg;

    // Monitor operating state
    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        CHECK = 2'b01,
        HALT  = 2'b10
    } mon_state_e;

    // S/R request encoding, packed as {s, r}
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count up on inc, stick at all-ones, clear on rst or clr
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/sr_ff_monitor.sv
// Passive checker for an SR flip-flop: golden model, mismatch and
// illegal-request detection, saturating statistics.
module sr_ff_monitor
    import sr_mon_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int MAX_ERR        = 8,
    parameter bit ILLEGAL_RESYNC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_stats,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             q_bar,
    output logic             err_pulse,
    output logic             illegal_pulse,
    output logic             err_sticky,
    output logic             halted,
    output logic             synced,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W:0] MAX_ERR_W = (CNT_W+1)'(MAX_ERR);

    mon_state_e     state_r;
    mon_state_e     state_nxt_s;
    logic           exp_q_r;
    logic           exp_q_nxt_s;
    logic [1:0]     req_s;
    logic           mism_ev_s;
    logic           ill_ev_s;
    logic           halt_hit_s;
    logic [CNT_W:0] mis_plus_s;
    logic           err_pulse_r;
    logic           illegal_pulse_r;
    logic           err_sticky_r;
    logic           synced_s;
    logic           halted_s;

    assign req_s      = {s, r};
    assign mis_plus_s = {1'b0, mismatch_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // State and model register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SYNC;
            exp_q_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            exp_q_r <= exp_q_nxt_s;
        end
    end

    // Next state, model update and event detection; clr_stats suppresses events
    always_comb begin
        state_nxt_s = state_r;
        exp_q_nxt_s = exp_q_r;
        mism_ev_s   = 1'b0;
        ill_ev_s    = 1'b0;
        halt_hit_s  = 1'b0;
        if (clr_stats) begin
            if (state_r == HALT) begin
                state_nxt_s = SYNC;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (en) begin
            case (state_r)
                SYNC: begin
                    case (req_s)
                        SET: begin
                            exp_q_nxt_s = 1'b1;
                            state_nxt_s = CHECK;
                        end
                        RST: begin
                            exp_q_nxt_s = 1'b0;
                            state_nxt_s = CHECK;
                        end
                        ILL:     ill_ev_s = 1'b1;
                        default: state_nxt_s = SYNC;
                    endcase
                end
                CHECK: begin
                    // compare against the value predicted on the previous edge
                    mism_ev_s  = (q != exp_q_r) || (q_bar == q);
                    halt_hit_s = (MAX_ERR > 0) && mism_ev_s && (mis_plus_s >= MAX_ERR_W);
                    case (req_s)
                        SET: exp_q_nxt_s = 1'b1;
                        RST: exp_q_nxt_s = 1'b0;
                        ILL: begin
                            ill_ev_s = 1'b1;
                            if (ILLEGAL_RESYNC) begin
                                state_nxt_s = SYNC;
                            end else begin
                                exp_q_nxt_s = exp_q_r;
                            end
                        end
                        default: exp_q_nxt_s = exp_q_r;
                    endcase
                    if (halt_hit_s) begin
                        state_nxt_s = HALT;
                    end else begin
                        halt_hit_s = 1'b0;
                    end
                end
                HALT: begin
                    if (req_s == ILL) begin
                        ill_ev_s = 1'b1;
                    end else begin
                        ill_ev_s = 1'b0;
                    end
                end
                default: state_nxt_s = SYNC;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State decode for status outputs
    always_comb begin
        synced_s = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            CHECK:   synced_s = 1'b1;
            HALT:    halted_s = 1'b1;
            default: synced_s = 1'b0;
        endcase
    end

    // Registered event pulses and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_r     <= 1'b0;
            illegal_pulse_r <= 1'b0;
            err_sticky_r    <= 1'b0;
        end else if (clr_stats) begin
            err_pulse_r     <= 1'b0;
            illegal_pulse_r <= 1'b0;
            err_sticky_r    <= 1'b0;
        end else begin
            err_pulse_r     <= mism_ev_s;
            illegal_pulse_r <= ill_ev_s;
            err_sticky_r    <= err_sticky_r | mism_ev_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (en),
        .cnt (sample_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (mism_ev_s),
        .cnt (mismatch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_illegal_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (ill_ev_s),
        .cnt (illegal_cnt)
    );

    assign err_pulse     = err_pulse_r;
    assign illegal_pulse = illegal_pulse_r;
    assign err_sticky    = err_sticky_r;
    assign synced        = synced_s;
    assign halted        = halted_s;

endmodule
